silife_grid_engine: RTL and testbench
=====================================

// Module: silife_grid_engine
// PURPOSE
//   ROWS x COLS cellular-automaton grid that updates every cell in one clock per generation.
//   The life rule is programmable in B/S form through birth/survive masks.
//   Edges are either dead or toroidal (wrap); a single-cell write port loads patterns.
//   A step/run controller emits one step per request or one step every PERIOD cycles.
//   Reports the generation count, population, and stable/extinct status to the display/host logic.
// PARAMETERS
//   ROWS   8   grid rows (>=3)
//   COLS   8   grid columns (>=3)
//   GEN_W  16  width of generation counter
//   DIV_W  16  width of run-mode period register
// PORTS
//   clk           in   1             clock, all logic on rising edge
//   rst_n         in   1             synchronous, active-low reset
//   step          in   1             request one generation (pulse)
//   run           in   1             free-running mode when high
//   period        in   DIV_W         run mode: cycles between steps minus 1
//   wrap          in   1             1 = toroidal edges, 0 = off-grid cells dead
//   birth_rule    in   9             bit k set: dead cell with k live neighbours is born
//   survive_rule  in   9             bit k set: live cell with k live neighbours survives
//   wr_en         in   1             write one cell
//   wr_row        in   $clog2(ROWS)  write row index
//   wr_col        in   $clog2(COLS)  write column index
//   wr_data       in   1             value written (1 = revive, 0 = kill)
//   clear         in   1             kill all cells, zero generation
//   cells         out  ROWS*COLS     state; cell (r,c) = cells[r*COLS+c]
//   generation    out  GEN_W         generations executed since reset/clear
//   population    out  $clog2(ROWS*COLS+1)  live-cell count of cells
//   stable        out  1             last executed step changed no cell
//   extinct       out  1             population == 0
//   step_done     out  1             one-cycle pulse in the cycle after a generation commits
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): cells=0, generation=0, stable=0, step_done=0, pending=0, run timer=0.
//   - Neighbour count n: 4-bit sum over 8 neighbours, range 0..8.
//     wrap=1: index (r+-1) mod ROWS, (c+-1) mod COLS. wrap=0: out-of-range neighbours count 0.
//   - Next state: cell ? survive_rule[n] : birth_rule[n].
//     B3/S23 = birth 9'h008, survive 9'h00C.
//   - Priority per cycle: rst_n > clear > wr_en > step execution.
//   - clear: cells=0, generation=0, stable=0, pending=0. Any step in the same cycle is discarded.
//   - wr_en: cells[wr_row*COLS+wr_col] <= wr_data next edge.
//     Out-of-range indices are ignored (no change); stable is not modified.
//   - Step sources: step pulse, or run=1 with timer reaching period (timer reloads to 0).
//     period=0 in run mode gives a step every cycle.
//   - A step source asserted in the same cycle as wr_en/clear sets pending.
//     The pending step executes on the first cycle with no wr_en/clear.
//     Multiple requests while pending merge into one.
//   - Step execution: all cells update simultaneously from pre-edge state.
//     generation += 1 mod 2^GEN_W, wrapping silently.
//     stable <= (next == cells). step_done=1 on the following cycle.
//   - Latency: step sampled at edge k -> cells/generation updated at edge k -> step_done high cycle k+1.
//   - Rules and wrap are sampled combinationally at the executing edge; changing them between steps is legal.
//   - run deasserted: timer holds at 0. Explicit step is still honoured while run=1.
//     A step coinciding with a timer step gives a single generation.
//   - population, extinct: combinational from cells.
//   - rst_n low mid-run or while pending: all state returns to reset values on that edge.
// TESTING
//   1. Blinker 8x8, B3/S23, wrap=0: write (3,2),(3,3),(3,4); step -> cells (2,3),(3,3),(4,3);
//      step -> original; generation=2, population=3, stable=0.
//   2. Block (1,1),(1,2),(2,1),(2,2); step -> unchanged, stable=1, population=4.
//   3. Glider at top-left, wrap=1: 32 steps on 8x8 -> identical pattern (torus period 4*8), generation=32.
//      Same with wrap=0 -> glider dies at the corner and becomes a block.
//   4. Rule B1/S (birth 9'h002, survive 0): single cell at (4,4), step -> 8 neighbours live, centre dead, population=8.
//   5. step and wr_en same cycle -> write lands first, generation increments one cycle later, step_done follows.
//      clear with step -> cells=0, generation=0, no step_done.
//   6. run=1, period=3 -> step_done every 4 cycles.
//      rst_n=0 mid-run -> all outputs 0 next edge.
//      GEN_W=4: 17 steps -> generation=1.

Source files
------------

// File: rtl/silife_grid_engine.sv
// Programmable-rule cellular automaton grid: every cell advances in a single clock per generation.
// Includes a single-cell write port, clear, and a step/run controller with pending-step merging.
module silife_grid_engine #(
    parameter int unsigned ROWS  = 8,
    parameter int unsigned COLS  = 8,
    parameter int unsigned GEN_W = 16,
    parameter int unsigned DIV_W = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              step,
    input  logic                              run,
    input  logic [DIV_W-1:0]                  period,
    input  logic                              wrap,
    input  logic [8:0]                        birth_rule,
    input  logic [8:0]                        survive_rule,
    input  logic                              wr_en,
    input  logic [$clog2(ROWS)-1:0]           wr_row,
    input  logic [$clog2(COLS)-1:0]           wr_col,
    input  logic                              wr_data,
    input  logic                              clear,
    output logic [ROWS*COLS-1:0]              cells,
    output logic [GEN_W-1:0]                  generation,
    output logic [$clog2(ROWS*COLS+1)-1:0]    population,
    output logic                              stable,
    output logic                              extinct,
    output logic                              step_done
);

    localparam int unsigned Cells = ROWS * COLS;
    localparam int unsigned PopW  = $clog2(Cells + 1);

    logic [Cells-1:0] cells_q, cells_d, next_cells;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic             stable_q, stable_d;
    logic             done_q, done_d;
    logic             pending_q, pending_d;
    logic             timer_hit, step_req, wr_ok;
    int unsigned      wr_idx;
    logic [PopW-1:0]  pop;

    // Neighbour sums use fixed wiring; the wrap flag only masks off-grid contributions.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned RU = (r + ROWS - 1) % ROWS;
            localparam int unsigned RD = (r + 1) % ROWS;
            localparam int unsigned CL = (c + COLS - 1) % COLS;
            localparam int unsigned CR = (c + 1) % COLS;
            localparam bit HasU = (r > 0);
            localparam bit HasD = (r < ROWS - 1);
            localparam bit HasL = (c > 0);
            localparam bit HasR = (c < COLS - 1);

            logic       vu, vd, vl, vr;
            logic [7:0] nb;
            logic [3:0] n;

            assign vu = wrap | HasU;
            assign vd = wrap | HasD;
            assign vl = wrap | HasL;
            assign vr = wrap | HasR;

            assign nb[0] = cells_q[RU*COLS + CL] & vu & vl;
            assign nb[1] = cells_q[RU*COLS + c]  & vu;
            assign nb[2] = cells_q[RU*COLS + CR] & vu & vr;
            assign nb[3] = cells_q[r*COLS + CL]  & vl;
            assign nb[4] = cells_q[r*COLS + CR]  & vr;
            assign nb[5] = cells_q[RD*COLS + CL] & vd & vl;
            assign nb[6] = cells_q[RD*COLS + c]  & vd;
            assign nb[7] = cells_q[RD*COLS + CR] & vd & vr;

            assign n = 4'(nb[0]) + 4'(nb[1]) + 4'(nb[2]) + 4'(nb[3])
                     + 4'(nb[4]) + 4'(nb[5]) + 4'(nb[6]) + 4'(nb[7]);

            assign next_cells[r*COLS + c] = cells_q[r*COLS + c] ? survive_rule[n] : birth_rule[n];
        end
    end

    assign timer_hit = run && (timer_q == period);
    assign step_req  = step | timer_hit;
    assign wr_ok     = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
    assign wr_idx    = 32'(wr_row) * COLS + 32'(wr_col);

    always_comb begin
        timer_d   = run ? (timer_hit ? '0 : timer_q + 1'b1) : '0;
        cells_d   = cells_q;
        gen_d     = gen_q;
        stable_d  = stable_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        if (clear) begin
            cells_d   = '0;
            gen_d     = '0;
            stable_d  = 1'b0;
            pending_d = 1'b0;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < Cells; i++) begin
                if (wr_ok && i == wr_idx) cells_d[i] = wr_data;
            end
            // A step blocked by the write is deferred, merging with any already pending.
            pending_d = pending_q | step_req;
        end else if (step_req || pending_q) begin
            cells_d   = next_cells;
            gen_d     = gen_q + 1'b1;
            stable_d  = (next_cells == cells_q);
            pending_d = 1'b0;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cells_q   <= '0;
            gen_q     <= '0;
            timer_q   <= '0;
            stable_q  <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            cells_q   <= cells_d;
            gen_q     <= gen_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            done_q    <= done_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < Cells; i++) begin
            pop = pop + PopW'(cells_q[i]);
        end
    end

    assign cells      = cells_q;
    assign generation = gen_q;
    assign population = pop;
    assign stable     = stable_q;
    assign extinct    = (pop == '0);
    assign step_done  = done_q;

endmodule

// File: tb/tb_silife_grid_engine.sv
// Directed bench for silife_grid_engine: classic patterns, rule change, port priorities, run mode,
// and generation wrap on a narrow-counter second instance sharing the same stimulus.
module tb_silife_grid_engine;

    logic        clk = 1'b0;
    logic        rst_n, step, run, wrap, wr_en, wr_data, clear;
    logic [15:0] period;
    logic [8:0]  birth_rule, survive_rule;
    logic [2:0]  wr_row, wr_col;

    logic [63:0] cells, cells2;
    logic [15:0] generation;
    logic [3:0]  generation2;
    logic [6:0]  population, population2;
    logic        stable, extinct, step_done;
    logic        stable2, extinct2, step_done2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    silife_grid_engine #(.ROWS(8), .COLS(8), .GEN_W(16), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .step(step), .run(run), .period(period), .wrap(wrap),
        .birth_rule(birth_rule), .survive_rule(survive_rule), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .clear(clear), .cells(cells),
        .generation(generation), .population(population), .stable(stable), .extinct(extinct),
        .step_done(step_done)
    );

    silife_grid_engine #(.ROWS(8), .COLS(8), .GEN_W(4), .DIV_W(16)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .step(step), .run(run), .period(period), .wrap(wrap),
        .birth_rule(birth_rule), .survive_rule(survive_rule), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .clear(clear), .cells(cells2),
        .generation(generation2), .population(population2), .stable(stable2),
        .extinct(extinct2), .step_done(step_done2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] at(input int r, input int c);
        return 64'(1) << (r * 8 + c);
    endfunction

    task automatic write_cell(input int r, input int c, input logic v);
        wr_en   = 1'b1;
        wr_row  = 3'(r);
        wr_col  = 3'(c);
        wr_data = v;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic do_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    logic [63:0] exp_cells;
    logic [63:0] glider;

    initial begin
        rst_n = 1'b0; step = 1'b0; run = 1'b0; wrap = 1'b0; wr_en = 1'b0; wr_data = 1'b0;
        clear = 1'b0; period = '0; wr_row = '0; wr_col = '0;
        birth_rule = 9'h008; survive_rule = 9'h00C;
        tick();
        tick();
        check_eq("rst_cells", cells, 64'h0);
        check_eq("rst_gen", 64'(generation), 64'd0);
        check_eq("rst_stable", 64'(stable), 64'd0);
        check_eq("rst_done", 64'(step_done), 64'd0);
        check_eq("rst_extinct", 64'(extinct), 64'd1);
        check_eq("rst_pop", 64'(population), 64'd0);
        rst_n = 1'b1;

        // Blinker oscillates between horizontal and vertical
        write_cell(3, 2, 1'b1);
        write_cell(3, 3, 1'b1);
        write_cell(3, 4, 1'b1);
        check_eq("blink_load", cells, at(3, 2) | at(3, 3) | at(3, 4));
        check_eq("blink_gen0", 64'(generation), 64'd0);
        do_step();
        check_eq("blink_vert", cells, at(2, 3) | at(3, 3) | at(4, 3));
        check_eq("blink_done1", 64'(step_done), 64'd1);
        check_eq("blink_gen1", 64'(generation), 64'd1);
        do_step();
        check_eq("blink_horiz", cells, at(3, 2) | at(3, 3) | at(3, 4));
        check_eq("blink_gen2", 64'(generation), 64'd2);
        check_eq("blink_pop", 64'(population), 64'd3);
        check_eq("blink_stable", 64'(stable), 64'd0);
        tick();
        check_eq("blink_done_drop", 64'(step_done), 64'd0);

        // Block still life
        do_clear();
        check_eq("clear_cells", cells, 64'h0);
        check_eq("clear_gen", 64'(generation), 64'd0);
        write_cell(1, 1, 1'b1);
        write_cell(1, 2, 1'b1);
        write_cell(2, 1, 1'b1);
        write_cell(2, 2, 1'b1);
        do_step();
        check_eq("block_cells", cells, at(1, 1) | at(1, 2) | at(2, 1) | at(2, 2));
        check_eq("block_stable", 64'(stable), 64'd1);
        check_eq("block_pop", 64'(population), 64'd4);

        // Glider on a torus returns after 32 generations
        glider = at(0, 1) | at(1, 2) | at(2, 0) | at(2, 1) | at(2, 2);
        do_clear();
        wrap = 1'b1;
        write_cell(0, 1, 1'b1);
        write_cell(1, 2, 1'b1);
        write_cell(2, 0, 1'b1);
        write_cell(2, 1, 1'b1);
        write_cell(2, 2, 1'b1);
        for (int i = 0; i < 32; i++) do_step();
        check_eq("glider_torus", cells, glider);
        check_eq("glider_gen32", 64'(generation), 64'd32);

        // Same glider with dead edges settles into a corner block by generation 23
        do_clear();
        wrap = 1'b0;
        write_cell(0, 1, 1'b1);
        write_cell(1, 2, 1'b1);
        write_cell(2, 0, 1'b1);
        write_cell(2, 1, 1'b1);
        write_cell(2, 2, 1'b1);
        for (int i = 0; i < 24; i++) do_step();
        check_eq("glider_corner", cells, at(6, 6) | at(6, 7) | at(7, 6) | at(7, 7));
        check_eq("glider_corner_stable", 64'(stable), 64'd1);
        check_eq("glider_corner_gen", 64'(generation), 64'd24);

        // B1/S: lone cell becomes a ring of eight
        do_clear();
        birth_rule = 9'h002; survive_rule = 9'h000;
        write_cell(4, 4, 1'b1);
        do_step();
        exp_cells = at(3, 3) | at(3, 4) | at(3, 5) | at(4, 3) | at(4, 5)
                  | at(5, 3) | at(5, 4) | at(5, 5);
        check_eq("b1_ring", cells, exp_cells);
        check_eq("b1_pop", 64'(population), 64'd8);
        birth_rule = 9'h008; survive_rule = 9'h00C;

        // Step colliding with a write is deferred by one cycle
        do_clear();
        step = 1'b1;
        write_cell(0, 0, 1'b1);
        step = 1'b0;
        check_eq("pend_write_first", cells, at(0, 0));
        check_eq("pend_gen_held", 64'(generation), 64'd0);
        check_eq("pend_no_done", 64'(step_done), 64'd0);
        tick();
        check_eq("pend_gen_exec", 64'(generation), 64'd1);
        check_eq("pend_cells_exec", cells, 64'h0);
        check_eq("pend_done", 64'(step_done), 64'd1);
        check_eq("pend_extinct", 64'(extinct), 64'd1);

        // Step colliding with clear is discarded
        write_cell(5, 5, 1'b1);
        step = 1'b1; clear = 1'b1;
        tick();
        step = 1'b0; clear = 1'b0;
        check_eq("clrstep_cells", cells, 64'h0);
        check_eq("clrstep_gen", 64'(generation), 64'd0);
        check_eq("clrstep_done0", 64'(step_done), 64'd0);
        tick();
        check_eq("clrstep_done1", 64'(step_done), 64'd0);
        check_eq("clrstep_gen1", 64'(generation), 64'd0);

        // Run mode, period 3: one step every 4 cycles
        write_cell(1, 1, 1'b1);
        write_cell(1, 2, 1'b1);
        write_cell(2, 1, 1'b1);
        write_cell(2, 2, 1'b1);
        run = 1'b1; period = 16'd3;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq($sformatf("run_pulse%0d", i), 64'(step_done), 64'((i % 4) == 3));
        end
        check_eq("run_gen", 64'(generation), 64'd3);
        check_eq("run_stable", 64'(stable), 64'd1);

        // Reset mid-run
        rst_n = 1'b0;
        tick();
        check_eq("midrst_cells", cells, 64'h0);
        check_eq("midrst_gen", 64'(generation), 64'd0);
        check_eq("midrst_stable", 64'(stable), 64'd0);
        check_eq("midrst_done", 64'(step_done), 64'd0);
        rst_n = 1'b1; run = 1'b0; period = '0;

        // Narrow generation counter wraps modulo 16
        for (int i = 0; i < 17; i++) do_step();
        check_eq("gen16_wide", 64'(generation), 64'd17);
        check_eq("gen4_wrap", 64'(generation2), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
